lfsr_noise_chk: RTL and testbench

//  Receive-side checker for the neuron noise LFSR stream. Takes 32-bit noise words, locks onto
//  the sequence s[n] = s[n-3] ^ s[n-17] (bit 0 of each word first, words contiguous), then counts
//  bit errors against its own prediction. Used in bring-up and BIST on noise buses feeding neurons.

---
 rtl/lfsr_noise_chk.sv | 241 ++++++++++++++++++++++++
 tb/tb_lfsr_noise_chk.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_noise_chk.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_noise_chk
//  Description : Receive-side checker for the neuron noise LFSR stream
//                s[n] = s[n-3] ^ s[n-17]. Each 32-bit word carries stream
//                bits 32*t .. 32*t+31, with bit 0 first. The checker locks
//                onto the stream and then counts bit errors against its own
//                free-running prediction.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_noise_chk #(
    parameter int LOCK_WORDS   = 4,   // consecutive exact matches needed to lock
    parameter int BAD_BITS     = 4,   // a word with more errors than this is bad
    parameter int UNLOCK_WORDS = 4,   // consecutive bad words that drop lock
    parameter int CNT_W        = 32   // width of the error and word counters
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             clr,
    output logic             locked,
    output logic             err_flag,
    output logic [5:0]       cur_errs,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    // ------------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------------
    // The run counters never hold their terminal value: reaching it causes a
    // state change and a reset of the counter instead.
    localparam int GOOD_W = (LOCK_WORDS   > 1) ? $clog2(LOCK_WORDS + 1)   : 1;
    localparam int BAD_W  = (UNLOCK_WORDS > 1) ? $clog2(UNLOCK_WORDS + 1) : 1;
    // One spare bit above the wider of the counter and a popcount (6 bits),
    // so the addition itself can never wrap before the clamp looks at it.
    localparam int SUM_W  = ((CNT_W > 6) ? CNT_W : 6) + 1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Stream helper functions
    // ------------------------------------------------------------------------

    // The 32 stream bits that follow word w. Only w[31:15] is needed since the
    // deepest tap reaches back 17 bits.
    function automatic logic [31:0] next_word(input logic [31:0] w);
        logic [63:0] x;
        x = {32'd0, w};
        for (int m = 32; m < 64; m++) begin
            x[m] = x[m-3] ^ x[m-17];
        end
        return x[63:32];
    endfunction

    // True when w obeys the recurrence internally and does not carry the
    // all-zero lockup state in its last 17 bits (which would predict zeros
    // forever).
    function automatic logic consistent(input logic [31:0] w);
        logic ok;
        ok = 1'b1;
        for (int m = 17; m < 32; m++) begin
            if (w[m] != (w[m-3] ^ w[m-17])) begin
                ok = 1'b0;
            end
        end
        return ok && (w[31:15] != 17'd0);
    endfunction

    // Number of set bits in a 32-bit word (0..32).
    function automatic logic [5:0] popcount32(input logic [31:0] w);
        logic [5:0] c;
        c = 6'd0;
        for (int k = 0; k < 32; k++) begin
            c = c + {5'd0, w[k]};
        end
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t             state_q,    state_d;
    logic [31:0]        exp_q,      exp_d;
    logic [GOOD_W-1:0]  good_q,     good_d;
    logic [BAD_W-1:0]   bad_q,      bad_d;
    logic [5:0]         cur_errs_q, cur_errs_d;
    logic               err_flag_q, err_flag_d;
    logic [CNT_W-1:0]   err_cnt_q,  err_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [31:0]      w_next_in;
    logic [31:0]      w_next_exp;
    logic             w_in_consistent;
    logic             w_in_match;
    logic [5:0]       w_word_errs;
    logic             w_word_bad;
    logic [SUM_W-1:0] w_err_sum;
    logic [SUM_W-1:0] w_word_sum;
    logic [CNT_W-1:0] w_err_cnt_sat;
    logic [CNT_W-1:0] w_word_cnt_sat;

    assign w_next_in       = next_word(in_data);
    assign w_next_exp      = next_word(exp_q);
    assign w_in_consistent = consistent(in_data);
    assign w_in_match      = (in_data == exp_q);
    assign w_word_errs     = popcount32(in_data ^ exp_q);
    assign w_word_bad      = (int'(w_word_errs) > BAD_BITS);

    // Saturating accumulation: any carry into the spare bits clamps to all-ones.
    assign w_err_sum      = SUM_W'(err_cnt_q) + SUM_W'(w_word_errs);
    assign w_word_sum     = SUM_W'(word_cnt_q) + SUM_W'(1);
    assign w_err_cnt_sat  = (w_err_sum[SUM_W-1:CNT_W] != '0)  ? {CNT_W{1'b1}}
                                                              : w_err_sum[CNT_W-1:0];
    assign w_word_cnt_sat = (w_word_sum[SUM_W-1:CNT_W] != '0) ? {CNT_W{1'b1}}
                                                              : w_word_sum[CNT_W-1:0];

    // ------------------------------------------------------------------------
    // Next-state and output logic: everything holds unless a word is accepted
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        good_d     = good_q;
        bad_d      = bad_q;
        cur_errs_d = cur_errs_q;
        err_flag_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;

        if (in_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    // Seed the prediction from any word that looks like the stream.
                    if (w_in_consistent) begin
                        exp_d   = w_next_in;
                        good_d  = '0;
                        state_d = ST_VERIFY;
                    end
                end

                ST_VERIFY: begin
                    if (w_in_match) begin
                        exp_d = w_next_exp;
                        if (int'(good_q) + 1 >= LOCK_WORDS) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end else if (w_in_consistent) begin
                        // Wrong seed but a plausible word: restart from it.
                        exp_d  = w_next_in;
                        good_d = '0;
                    end else begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                    end
                end

                ST_LOCKED: begin
                    // Prediction free-runs so a corrupted word cannot poison it.
                    exp_d      = w_next_exp;
                    cur_errs_d = w_word_errs;
                    err_flag_d = (w_word_errs != 6'd0);
                    err_cnt_d  = w_err_cnt_sat;
                    word_cnt_d = w_word_cnt_sat;
                    if (w_word_bad) begin
                        if (int'(bad_q) + 1 >= UNLOCK_WORDS) begin
                            state_d = ST_SEARCH;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + BAD_W'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end

                default: begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end

        // Clear has priority over any accumulation in the same cycle; the
        // lock state machine and prediction keep advancing untouched.
        if (clr) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
            err_flag_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Register bank with asynchronous reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SEARCH;
            exp_q      <= 32'd0;
            good_q     <= '0;
            bad_q      <= '0;
            cur_errs_q <= 6'd0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            cur_errs_q <= cur_errs_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign locked   = (state_q == ST_LOCKED);
    assign err_flag = err_flag_q;
    assign cur_errs = cur_errs_q;
    assign err_cnt  = err_cnt_q;
    assign word_cnt = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_noise_chk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_noise_chk
//  Description : Directed self-checking bench for lfsr_noise_chk. Counters
//                are built 8 bits wide so saturation is reachable by traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_noise_chk;

    localparam int CW = 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data  = 32'd0;
    logic          clr      = 1'b0;
    logic          locked;
    logic          err_flag;
    logic [5:0]    cur_errs;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] word_cnt;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   w;

    lfsr_noise_chk #(
        .LOCK_WORDS   (4),
        .BAD_BITS     (4),
        .UNLOCK_WORDS (4),
        .CNT_W        (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .clr      (clr),
        .locked   (locked),
        .err_flag (err_flag),
        .cur_errs (cur_errs),
        .err_cnt  (err_cnt),
        .word_cnt (word_cnt)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // One comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word for one clock edge; starts and ends at a falling edge,
    // so outputs seen right afterwards belong to this word.
    task automatic send(input logic [31:0] d, input logic c);
        in_valid = 1'b1;
        in_data  = d;
        clr      = c;
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference stream generator: bit-serial over a 17-bit history where
    // h[16] is the newest bit, h[14] is s[n-3] and h[0] is s[n-17].
    function automatic logic [31:0] gen(input logic [31:0] p);
        logic [16:0] h;
        logic [31:0] r;
        logic        b;
        h = p[31:15];
        r = 32'd0;
        for (int k = 0; k < 32; k++) begin
            b    = h[14] ^ h[0];
            r[k] = b;
            h    = {b, h[16:1]};
        end
        return r;
    endfunction

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle(2);
        check("rst_locked",   32'(locked),   32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_cur_errs", 32'(cur_errs), 32'd0);
        check("rst_err_cnt",  32'(err_cnt),  32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // ---------------- lock on seeded stream ----------------
        w = 32'h2492_0001;
        send(w, 1'b0);                       // SEARCH -> VERIFY
        for (int i = 0; i < 3; i++) begin    // three matches
            w = gen(w);
            send(w, 1'b0);
        end
        check("verify_not_locked", 32'(locked), 32'd0);
        w = gen(w);
        send(w, 1'b0);                       // fourth match
        check("lock_locked",   32'(locked),   32'd1);
        check("lock_err_cnt",  32'(err_cnt),  32'd0);
        check("lock_word_cnt", 32'(word_cnt), 32'd0);

        // ---------------- two-bit error ----------------
        w = gen(w);
        send(w ^ 32'h0000_0201, 1'b0);
        check("e2_cur_errs", 32'(cur_errs), 32'd2);
        check("e2_err_flag", 32'(err_flag), 32'd1);
        check("e2_err_cnt",  32'(err_cnt),  32'd2);
        check("e2_word_cnt", 32'(word_cnt), 32'd1);
        check("e2_locked",   32'(locked),   32'd1);
        w = gen(w);
        send(w, 1'b0);
        check("clean_cur_errs", 32'(cur_errs), 32'd0);
        check("clean_err_flag", 32'(err_flag), 32'd0);
        check("clean_err_cnt",  32'(err_cnt),  32'd2);
        check("clean_word_cnt", 32'(word_cnt), 32'd2);

        // ---------------- four bad words drop lock ----------------
        for (int i = 0; i < 3; i++) begin
            w = gen(w);
            send(w ^ 32'h0000_00FF, 1'b0);
        end
        check("bad3_locked",  32'(locked),  32'd1);
        check("bad3_err_cnt", 32'(err_cnt), 32'd26);
        w = gen(w);
        send(w ^ 32'h0000_00FF, 1'b0);
        check("bad4_locked",   32'(locked),   32'd0);
        check("bad4_err_cnt",  32'(err_cnt),  32'd34);
        check("bad4_word_cnt", 32'(word_cnt), 32'd6);
        check("bad4_cur_errs", 32'(cur_errs), 32'd8);
        check("bad4_err_flag", 32'(err_flag), 32'd1);
        idle(1);
        check("pulse_end_flag", 32'(err_flag), 32'd0);

        // ---------------- lockup / inconsistent words ----------------
        send(32'h0000_0000, 1'b0);
        send(32'h0000_0000, 1'b0);
        send(32'h0000_0000, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h0000_0000, 1'b0);
        check("search_locked",   32'(locked),   32'd0);
        check("search_err_cnt",  32'(err_cnt),  32'd34);
        check("search_word_cnt", 32'(word_cnt), 32'd6);
        check("search_err_flag", 32'(err_flag), 32'd0);

        // ---------------- async reset mid-VERIFY ----------------
        for (int i = 0; i < 3; i++) begin
            w = gen(w);
            send(w, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rstv_locked",   32'(locked),   32'd0);
        check("rstv_err_cnt",  32'(err_cnt),  32'd0);
        check("rstv_word_cnt", 32'(word_cnt), 32'd0);
        check("rstv_cur_errs", 32'(cur_errs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Relock with random gaps between words
        for (int i = 0; i < 5; i++) begin
            w = gen(w);
            send(w, 1'b0);
            if (i == 3) check("gap_not_locked", 32'(locked), 32'd0);
            idle($urandom_range(0, 2));
        end
        check("gap_locked", 32'(locked), 32'd1);

        // ---------------- async reset mid-LOCKED ----------------
        w = gen(w);
        send(w ^ 32'h0000_0001, 1'b0);
        check("e1_cur_errs", 32'(cur_errs), 32'd1);
        check("e1_err_flag", 32'(err_flag), 32'd1);
        check("e1_err_cnt",  32'(err_cnt),  32'd1);
        check("e1_word_cnt", 32'(word_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstl_locked",   32'(locked),   32'd0);
        check("rstl_err_flag", 32'(err_flag), 32'd0);
        check("rstl_cur_errs", 32'(cur_errs), 32'd0);
        check("rstl_err_cnt",  32'(err_cnt),  32'd0);
        check("rstl_word_cnt", 32'(word_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- saturation and clear ----------------
        for (int i = 0; i < 5; i++) begin
            w = gen(w);
            send(w, 1'b0);
        end
        check("sat_relocked", 32'(locked), 32'd1);
        // 32-error words with a clean word after every third to keep lock
        for (int j = 0; j < 10; j++) begin
            w = gen(w);
            if (j == 3 || j == 7) send(w, 1'b0);
            else                  send(~w, 1'b0);
            if (j == 8) check("sat_224", 32'(err_cnt), 32'd224);
        end
        check("sat_err_cnt",  32'(err_cnt),  32'd255);
        check("sat_word_cnt", 32'(word_cnt), 32'd10);
        w = gen(w);
        send(~w, 1'b0);
        check("sat_hold_err_cnt",  32'(err_cnt),  32'd255);
        check("sat_hold_word_cnt", 32'(word_cnt), 32'd11);
        check("sat_hold_locked",   32'(locked),   32'd1);
        w = gen(w);
        send(w, 1'b0);
        w = gen(w);
        send(~w, 1'b1);                      // clear with an erroring word
        check("clr_err_cnt",  32'(err_cnt),  32'd0);
        check("clr_word_cnt", 32'(word_cnt), 32'd0);
        check("clr_locked",   32'(locked),   32'd1);
        w = gen(w);
        send(w, 1'b0);
        check("post_clr_word_cnt", 32'(word_cnt), 32'd1);
        check("post_clr_err_cnt",  32'(err_cnt),  32'd0);
        check("post_clr_cur_errs", 32'(cur_errs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
